// File: rtl/sysarray_qr_seq.sv
// Sequencer for the Givens-rotation QR systolic array: clear, load A with column
// skew, drain, then stream query rows through the frozen R and flush.
module sysarray_qr_seq #(
  parameter int N     = 4,
  parameter int DW    = 16,
  parameter int M_MAX = 64,
  parameter int CW    = $clog2(M_MAX+1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [CW-1:0]   num_rows,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N*DW-1:0] in_data,
  input  logic            in_last,
  output logic [N*DW-1:0] arr_x,
  output logic [N-1:0]    arr_valid,
  output logic            arr_rst,
  output logic            arr_freeze,
  output logic [2:0]      state_o,
  output logic            busy,
  output logic            done
);
  // Skew depth plus array depth: time for the last injected element to leave the array.
  localparam int TAIL = 2*N-1;
  localparam int CNTW = $clog2(TAIL+1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_LOAD  = 3'd2,
    S_DRAIN = 3'd3,
    S_APPLY = 3'd4,
    S_FLUSH = 3'd5
  } state_t;

  state_t          state;
  logic [CW-1:0]   rows_left;
  logic [CNTW-1:0] cnt;
  logic            freeze_q, done_q;
  logic            fire;

  assign in_ready   = (state == S_LOAD && rows_left != '0) || state == S_APPLY;
  assign fire       = in_valid && in_ready;
  assign arr_rst    = rst || state == S_CLEAR;
  assign arr_freeze = freeze_q;
  assign done       = done_q;
  assign busy       = state != S_IDLE;
  assign state_o    = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      rows_left <= '0;
      cnt       <= '0;
      freeze_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          state     <= S_CLEAR;
          rows_left <= num_rows;
        end
        S_CLEAR: if (rows_left == '0) begin
          state <= S_DRAIN;
          cnt   <= CNTW'(TAIL-1);
        end else begin
          state <= S_LOAD;
        end
        S_LOAD: if (fire && rows_left != '0) begin
          rows_left <= rows_left - CW'(1);
          if (rows_left == CW'(1)) begin
            state <= S_DRAIN;
            cnt   <= CNTW'(TAIL-1);
          end
        end
        S_DRAIN: if (cnt == '0) begin
          state    <= S_APPLY;
          freeze_q <= 1'b1;
        end else begin
          cnt <= cnt - CNTW'(1);
        end
        S_APPLY: if (fire && in_last) begin
          state  <= S_FLUSH;
          cnt    <= CNTW'(TAIL-1);
          done_q <= (TAIL == 1);
        end
        S_FLUSH: if (cnt == '0) begin
          state    <= S_IDLE;
          freeze_q <= 1'b0;
        end else begin
          cnt    <= cnt - CNTW'(1);
          done_q <= (cnt == CNTW'(1));
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Column j is delayed j+1 cycles; bubbles and idle cycles shift in neutral zero rows.
  for (genvar j = 0; j < N; j++) begin : g_col
    logic [j:0][DW-1:0] sr;
    logic [j:0]         sv;
    always_ff @(posedge clk) begin
      if (rst) begin
        sr <= '0;
        sv <= '0;
      end else begin
        sr[0] <= fire ? in_data[j*DW +: DW] : '0;
        sv[0] <= fire;
        for (int i = 1; i <= j; i++) begin
          sr[i] <= sr[i-1];
          sv[i] <= sv[i-1];
        end
      end
    end
    assign arr_x[j*DW +: DW] = sr[j];
    assign arr_valid[j]      = sv[j];
  end
endmodule

// File: tb/tb_sysarray_qr_seq.sv
// Bench for sysarray_qr_seq: scripted batch phases plus a history of injected rows
// from which the skewed array feed is predicted.
module tb_sysarray_qr_seq;
  localparam int N = 4, DW = 16, M_MAX = 64, CW = $clog2(M_MAX+1), TAIL = 2*N-1;
  localparam logic [2:0] IDLE = 3'd0, CLEAR = 3'd1, LOAD = 3'd2, DRAIN = 3'd3,
                         APPLY = 3'd4, FLUSH = 3'd5;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, in_valid = 1'b0, in_last = 1'b0;
  logic [CW-1:0]   num_rows = '0;
  logic [N*DW-1:0] in_data = '0;
  logic            in_ready, arr_rst, arr_freeze, busy, done;
  logic [N*DW-1:0] arr_x;
  logic [N-1:0]    arr_valid;
  logic [2:0]      state_o;

  int errors = 0, checks = 0;
  logic tb_fire = 1'b0;
  logic [DW-1:0] hist_x [4096][N];
  logic          hist_v [4096];
  int cyc = 16;

  sysarray_qr_seq #(.N(N), .DW(DW), .M_MAX(M_MAX), .CW(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .num_rows(num_rows),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .arr_x(arr_x), .arr_valid(arr_valid), .arr_rst(arr_rst), .arr_freeze(arr_freeze),
    .state_o(state_o), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 4096; i++) begin
      hist_v[i] = 1'b0;
      for (int j = 0; j < N; j++) hist_x[i][j] = '0;
    end
  end

  // Record what the bench intends to inject each edge; reset wipes the skew pipes.
  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N; k++) begin
        hist_v[(cyc-k) & 4095] = 1'b0;
        for (int j = 0; j < N; j++) hist_x[(cyc-k) & 4095][j] = '0;
      end
    end else begin
      hist_v[cyc & 4095] = tb_fire;
      for (int j = 0; j < N; j++)
        hist_x[cyc & 4095][j] = tb_fire ? in_data[j*DW +: DW] : '0;
    end
    cyc = cyc + 1;
  end

  function automatic logic [N*DW-1:0] exp_x();
    logic [N*DW-1:0] r = '0;
    for (int j = 0; j < N; j++) r[j*DW +: DW] = hist_x[(cyc-1-j) & 4095][j];
    return r;
  endfunction

  function automatic logic [N-1:0] exp_v();
    logic [N-1:0] r = '0;
    for (int j = 0; j < N; j++) r[j] = hist_v[(cyc-1-j) & 4095];
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One full batch; nxt is the state expected after each edge, derived from row counts.
  task automatic run_batch(input int nrows, input int napply, input int bub, input int pat,
                           input bit seq, input bit poke, input string tag);
    logic [2:0] cur, nxt;
    int sent = 0, got = 0, dcnt = 0, fcnt = 0, lcyc = 0, dones = 0, guard = 0;
    bit v, ed;
    cur = IDLE;
    do begin
      in_valid = 1'b0; in_last = 1'b0; tb_fire = 1'b0; start = 1'b0; v = 1'b0;
      for (int j = 0; j < N; j++) in_data[j*DW +: DW] = DW'($urandom);
      nxt = IDLE;
      case (cur)
        IDLE: begin start = 1'b1; num_rows = CW'(nrows); nxt = CLEAR; end
        CLEAR: nxt = (nrows == 0) ? DRAIN : LOAD;
        LOAD: begin
          v = (pat != 0 && lcyc < 32) ? pat[lcyc] : ($urandom_range(99) >= bub);
          lcyc++;
          if (v && seq)
            for (int j = 0; j < N; j++) in_data[j*DW +: DW] = DW'(sent*N + j + 1);
          in_valid = v; tb_fire = v;
          if (v) sent++;
          nxt = (sent == nrows) ? DRAIN : LOAD;
        end
        DRAIN: begin in_valid = 1'($urandom_range(1)); dcnt++; nxt = (dcnt == TAIL) ? APPLY : DRAIN; end
        APPLY: begin
          v = ($urandom_range(99) >= bub);
          in_valid = v; tb_fire = v;
          if (v) begin got++; in_last = (got == napply); end
          else in_last = 1'($urandom_range(1));
          if (poke) begin start = 1'b1; num_rows = CW'($urandom_range(M_MAX)); end
          nxt = (v && got == napply) ? FLUSH : APPLY;
        end
        FLUSH: begin in_valid = 1'($urandom_range(1)); fcnt++; nxt = (fcnt == TAIL) ? IDLE : FLUSH; end
        default: nxt = IDLE;
      endcase
      ed = (nxt == FLUSH) && (fcnt + 1 == TAIL);
      step();
      checks++; if (state_o !== nxt) begin errors++; $display("FAIL %s state cyc=%0d got=%0d exp=%0d", tag, cyc, state_o, nxt); end
      checks++; if (in_ready !== (nxt == APPLY || nxt == LOAD)) begin errors++; $display("FAIL %s in_ready cyc=%0d got=%b st=%0d", tag, cyc, in_ready, nxt); end
      checks++; if (arr_freeze !== (nxt == APPLY || nxt == FLUSH)) begin errors++; $display("FAIL %s freeze cyc=%0d got=%b st=%0d", tag, cyc, arr_freeze, nxt); end
      checks++; if (arr_rst !== (nxt == CLEAR)) begin errors++; $display("FAIL %s arr_rst cyc=%0d got=%b st=%0d", tag, cyc, arr_rst, nxt); end
      checks++; if (busy !== (nxt != IDLE)) begin errors++; $display("FAIL %s busy cyc=%0d got=%b st=%0d", tag, cyc, busy, nxt); end
      checks++; if (done !== ed) begin errors++; $display("FAIL %s done cyc=%0d got=%b exp=%b", tag, cyc, done, ed); end
      checks++; if (arr_x !== exp_x()) begin errors++; $display("FAIL %s arr_x cyc=%0d got=%h exp=%h", tag, cyc, arr_x, exp_x()); end
      checks++; if (arr_valid !== exp_v()) begin errors++; $display("FAIL %s arr_valid cyc=%0d got=%b exp=%b", tag, cyc, arr_valid, exp_v()); end
      if (done === 1'b1) dones++;
      cur = nxt;
      guard++;
    end while (cur != IDLE && guard < 2000);
    in_valid = 1'b0; in_last = 1'b0; tb_fire = 1'b0; start = 1'b0;
    checks++; if (guard >= 2000) begin errors++; $display("FAIL %s timeout got=%0d cycles limit=2000", tag, guard); end
    checks++; if (dones != 1) begin errors++; $display("FAIL %s done_count got=%0d exp=1", tag, dones); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    checks++; if (state_o !== IDLE) begin errors++; $display("FAIL reset state got=%0d exp=0", state_o); end
    checks++; if (arr_x !== '0) begin errors++; $display("FAIL reset arr_x got=%h exp=0", arr_x); end
    checks++; if (arr_valid !== '0) begin errors++; $display("FAIL reset arr_valid got=%b exp=0", arr_valid); end
    checks++; if ({arr_freeze, in_ready, done, busy} !== 4'b0) begin errors++; $display("FAIL reset flags got=%b exp=0000", {arr_freeze, in_ready, done, busy}); end
    checks++; if (arr_rst !== 1'b1) begin errors++; $display("FAIL reset arr_rst got=%b exp=1", arr_rst); end
    rst = 1'b0;
    step();
    checks++; if (arr_rst !== 1'b0) begin errors++; $display("FAIL reset arr_rst_release got=%b exp=0", arr_rst); end
    checks++; if (state_o !== IDLE) begin errors++; $display("FAIL reset idle_hold got=%0d exp=0", state_o); end
  endtask

  task automatic test_basic();        run_batch(3, 2, 0, 0, 1'b1, 1'b0, "basic"); endtask
  task automatic test_bubbles();      run_batch(3, 3, 30, 25, 1'b1, 1'b0, "bubbles"); endtask
  task automatic test_zero_rows();    run_batch(0, 1, 0, 0, 1'b0, 1'b0, "zero_rows"); endtask
  task automatic test_apply_flush();  run_batch(2, 4, 50, 0, 1'b0, 1'b0, "apply_flush"); endtask
  task automatic test_start_ignored(); run_batch(3, 3, 40, 0, 1'b1, 1'b1, "start_ignored"); endtask

  task automatic test_mid_reset();
    start = 1'b1; num_rows = CW'(3);
    step();
    start = 1'b0;
    checks++; if (state_o !== CLEAR) begin errors++; $display("FAIL mid_reset clear got=%0d exp=1", state_o); end
    step();
    in_valid = 1'b1; tb_fire = 1'b1;
    for (int j = 0; j < N; j++) in_data[j*DW +: DW] = DW'($urandom);
    step();
    in_valid = 1'b0; tb_fire = 1'b0;
    checks++; if (state_o !== LOAD) begin errors++; $display("FAIL mid_reset load got=%0d exp=2", state_o); end
    checks++; if (arr_x !== exp_x()) begin errors++; $display("FAIL mid_reset first_row got=%h exp=%h", arr_x, exp_x()); end
    rst = 1'b1;
    #1;
    checks++; if (arr_rst !== 1'b1) begin errors++; $display("FAIL mid_reset arr_rst got=%b exp=1", arr_rst); end
    step();
    rst = 1'b0;
    checks++; if (state_o !== IDLE) begin errors++; $display("FAIL mid_reset state got=%0d exp=0", state_o); end
    checks++; if (arr_x !== '0 || arr_valid !== '0) begin errors++; $display("FAIL mid_reset pipes got=%h/%b exp=0", arr_x, arr_valid); end
    checks++; if ({arr_freeze, in_ready, busy, done} !== 4'b0) begin errors++; $display("FAIL mid_reset flags got=%b exp=0000", {arr_freeze, in_ready, busy, done}); end
    run_batch(2, 1, 20, 0, 1'b1, 1'b0, "restart");
  endtask

  task automatic test_back_to_back();
    for (int b = 0; b < 4; b++)
      run_batch($urandom_range(M_MAX), $urandom_range(6, 1), 35, 0, 1'b0, 1'b0, "random");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bubbles();
    test_zero_rows();
    test_apply_flush();
    test_mid_reset();
    test_start_ignored();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout got=%0d cycles limit=100000", cyc);
    $fatal(1, "timeout");
  end
endmodule
